// File: rtl/fetch_controller_if.sv
// Fetch-side bus bundle for fetch_controller.
//   imem_addr/imem_rdata          : combinational instruction-memory read
//   redirect_valid/redirect_pc    : branch/jump redirect request
//   if_valid/if_ready/if_pc/if_instr : one-entry output stage handshake to decode
// master = fetch_controller side, slave = memory/decode/branch side.
interface fetch_controller_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_pc,
    output if_instr
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_pc,
    input  if_instr
  );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, drives the instruction-memory address and
// registers {pc, instr} into a one-entry output stage handed to decode.
// Handles start, redirect, halt and end-of-memory.
// Ports:
//   clk, rst      : clock (rising edge), synchronous active-high reset
//   start         : begin fetching from RESET_PC (honoured in IDLE/DONE)
//   halt_req      : stop issuing fetches, drain the output stage
//   bus (master)  : imem / redirect / output-stage signals (fetch_controller_if)
//   busy          : high in FETCH or DRAIN
//   fetch_count   : instructions accepted by decode since start (saturating)
//   misalign_err  : sticky misaligned-redirect flag
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned redirects
// (no pc load, set misalign_err, drain and stop). Without it the redirect
// target is word-aligned by clearing bits [1:0] and misalign_err is tied 0.
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_BYTES = 16,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  fetch_controller_if.master bus,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_count,
  output logic             misalign_err
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  state_t      state;
  logic [31:0] pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic        accept;
  logic        end_of_mem;
  logic        redirect_take;
  logic        redirect_bad;
  logic        start_take;
  logic        count_inc;
  logic [31:0] redirect_target;

  assign accept          = if_valid && bus.if_ready;
  assign end_of_mem      = (pc >= IMEM_LIMIT);
  // halt_req outranks redirect; redirects outside FETCH are ignored.
  assign redirect_take   = (state == FETCH) && !halt_req && bus.redirect_valid;
  assign start_take      = start && ((state == IDLE) || (state == DONE));
  assign redirect_target = bus.redirect_pc & ~32'd3;
  // A flushed entry is not counted even if decode took it this cycle.
  assign count_inc       = accept && !redirect_take;

`ifdef MISALIGN_TRAP_EN
  assign redirect_bad = (bus.redirect_pc[1:0] != 2'b00);
`else
  assign redirect_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      fetch_count <= '0;
      busy        <= 1'b0;
    end else begin
      if (count_inc && (fetch_count != '1)) begin
        fetch_count <= fetch_count + CNT_W'(1);
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= FETCH;
            busy        <= 1'b1;
            pc          <= RESET_PC;
            fetch_count <= '0;
          end
        end

        FETCH: begin
          if (halt_req) begin
            state <= DRAIN;
            if (accept) begin
              if_valid <= 1'b0;
            end
          end else if (bus.redirect_valid) begin
            if_valid <= 1'b0;
            if (redirect_bad) begin
              state <= DRAIN;
            end else begin
              pc <= redirect_target;
            end
          end else if (end_of_mem) begin
            state <= DRAIN;
            if (accept) begin
              if_valid <= 1'b0;
            end
          end else if (!if_valid || bus.if_ready) begin
            // Stage is empty or being emptied this cycle: refill it.
            if_valid <= 1'b1;
            if_pc    <= pc;
            if_instr <= bus.imem_rdata;
            pc       <= pc + 32'd4;
          end
        end

        DRAIN: begin
          if (!if_valid || bus.if_ready) begin
            state    <= DONE;
            busy     <= 1'b0;
            if_valid <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst || start_take) begin
      misalign_err <= 1'b0;
    end else if (redirect_take && redirect_bad) begin
      misalign_err <= 1'b1;
    end
  end
`else
  assign misalign_err = 1'b0;
  logic unused_start_take;
  assign unused_start_take = start_take;
`endif

  assign bus.imem_addr = pc;
  assign bus.if_valid  = if_valid;
  assign bus.if_pc     = if_pc;
  assign bus.if_instr  = if_instr;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: directed vector table for the documented
// sequences, a saturation/end-of-memory sequence, then randomized stimulus
// against a queue-based behavioural model.
module tb_fetch_controller;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned IMEM_BYTES = 16;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  localparam logic [31:0] W0 = 32'hffc4a303;
  localparam logic [31:0] W1 = 32'h0064a423;
  localparam logic [31:0] W2 = 32'h0032e233;
  localparam logic [31:0] W3 = 32'hfe420ae3;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_DONE  = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             halt_req;
  logic             busy;
  logic [CNT_W-1:0] fetch_count;
  logic             misalign_err;
  logic [31:0]      mem [4];

  fetch_controller_if bus();

  always #5 clk = ~clk;

  assign bus.imem_rdata = (bus.imem_addr < 32'(IMEM_BYTES)) ? mem[bus.imem_addr[3:2]] : 32'hdeadbeef;

  fetch_controller #(
    .RESET_PC  (32'd0),
    .IMEM_BYTES(IMEM_BYTES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt_req    (halt_req),
    .bus         (bus.master),
    .busy        (busy),
    .fetch_count (fetch_count),
    .misalign_err(misalign_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  ent_t        stage[$];
  int          mode;
  logic [31:0] mpc;
  int          mcnt;
  logic        merr;

  function automatic void pop_count();
    void'(stage.pop_front());
    if (mcnt < CNT_MAX) mcnt++;
  endfunction

  function automatic void model_step();
    bit acc;
    ent_t e;
    if (rst) begin
      mode = M_IDLE; mpc = 32'd0; stage.delete(); mcnt = 0; merr = 1'b0;
    end else begin
      case (mode)
        M_IDLE, M_DONE: if (start) begin
          mode = M_RUN; mpc = 32'd0; mcnt = 0; merr = 1'b0;
        end
        M_RUN: begin
          acc = (stage.size() != 0) && bus.if_ready;
          if (halt_req) begin
            mode = M_DRAIN;
            if (acc) pop_count();
          end else if (bus.redirect_valid) begin
            stage.delete();
            if (TRAP && (bus.redirect_pc % 4 != 0)) begin
              merr = 1'b1; mode = M_DRAIN;
            end else begin
              mpc = bus.redirect_pc - (bus.redirect_pc % 4);
            end
          end else begin
            if (acc) pop_count();
            if (mpc >= IMEM_BYTES) mode = M_DRAIN;
            else if (stage.size() == 0) begin
              e.pc = mpc; e.ins = mem[mpc / 4];
              stage.push_back(e);
              mpc = mpc + 4;
            end
          end
        end
        M_DRAIN: begin
          if (stage.size() == 0) mode = M_DONE;
          else if (bus.if_ready) begin pop_count(); mode = M_DONE; end
        end
        default: mode = M_IDLE;
      endcase
    end
  endfunction

  task automatic check_model();
    chk("m_valid", bus.if_valid, (stage.size() != 0));
    if (stage.size() != 0) begin
      chk("m_if_pc", bus.if_pc, stage[0].pc);
      chk("m_if_instr", bus.if_instr, stage[0].ins);
    end
    chk("m_addr", bus.imem_addr, mpc);
    chk("m_busy", busy, (mode == M_RUN || mode == M_DRAIN));
    chk("m_count", fetch_count, mcnt);
    chk("m_err", misalign_err, merr);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        r, s, rd, h, rdy;
    logic [31:0] rp;
    logic        ev;
    logic [31:0] epc, eins, eaddr;
    logic        eb;
    int          ec;
    logic        ee;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic s, logic rd, logic [31:0] rp, logic h, logic rdy,
                             logic ev, logic [31:0] epc, logic [31:0] eins, logic [31:0] eaddr,
                             logic eb, int ec, logic ee);
    vec_t t;
    t.r = r; t.s = s; t.rd = rd; t.rp = rp; t.h = h; t.rdy = rdy;
    t.ev = ev; t.epc = epc; t.eins = eins; t.eaddr = eaddr; t.eb = eb; t.ec = ec; t.ee = ee;
    return t;
  endfunction

  initial begin
    mem[0] = W0; mem[1] = W1; mem[2] = W2; mem[3] = W3;
    rst = 1'b1; start = 1'b0; halt_req = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0; bus.if_ready = 1'b0;

    //            r  s  rd rp    h  rdy  ev epc    eins eaddr b  cnt err
    tbl.push_back(v(1, 0, 0, 0,  0, 0,   0, 0,  0,  0,  0, 0, 0));
    // straight-line program, if_ready=1
    tbl.push_back(v(0, 1, 0, 0,  0, 1,   0, 0,  0,  0,  1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 0,  W0, 4,  1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 4,  W1, 8,  1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 8,  W2, 12, 1, 2, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 12, W3, 16, 1, 3, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   0, 0,  0,  16, 1, 4, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   0, 0,  0,  16, 0, 4, 0));
    // backpressure while holding pc 4
    tbl.push_back(v(0, 1, 0, 0,  0, 0,   0, 0,  0,  0,  1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 0,   1, 0,  W0, 4,  1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 4,  W1, 8,  1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 0,   1, 4,  W1, 8,  1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 0,   1, 4,  W1, 8,  1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 0,   1, 4,  W1, 8,  1, 1, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 8,  W2, 12, 1, 2, 0));
    // redirect to 0 flushes the accepted pc 8 entry
    tbl.push_back(v(0, 0, 1, 0,  0, 1,   0, 0,  0,  0,  1, 2, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 0,  W0, 4,  1, 2, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 4,  W1, 8,  1, 3, 0));
    // halt + redirect: redirect ignored, pc 4 held until accepted
    tbl.push_back(v(0, 0, 1, 0,  1, 0,   1, 4,  W1, 8,  1, 3, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 0,   1, 4,  W1, 8,  1, 3, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   0, 0,  0,  8,  0, 4, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   0, 0,  0,  8,  0, 4, 0));
    // reset mid-fetch, then restart
    tbl.push_back(v(0, 1, 0, 0,  0, 1,   0, 0,  0,  0,  1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 0,  W0, 4,  1, 0, 0));
    tbl.push_back(v(1, 0, 0, 0,  0, 1,   0, 0,  0,  0,  0, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,  0, 1,   0, 0,  0,  0,  1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 0,  W0, 4,  1, 0, 0));
    // misaligned redirect to 6
`ifdef MISALIGN_TRAP_EN
    tbl.push_back(v(0, 0, 1, 6,  0, 1,   0, 0,  0,  4,  1, 0, 1));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   0, 0,  0,  4,  0, 0, 1));
`else
    tbl.push_back(v(0, 0, 1, 6,  0, 1,   0, 0,  0,  4,  1, 0, 0));
    tbl.push_back(v(0, 0, 0, 0,  0, 1,   1, 4,  W1, 8,  1, 0, 0));
`endif

    foreach (tbl[i]) begin
      rst = tbl[i].r; start = tbl[i].s; halt_req = tbl[i].h;
      bus.redirect_valid = tbl[i].rd; bus.redirect_pc = tbl[i].rp; bus.if_ready = tbl[i].rdy;
      tick();
      chk($sformatf("v%0d_valid", i), bus.if_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk($sformatf("v%0d_if_pc", i), bus.if_pc, tbl[i].epc);
        chk($sformatf("v%0d_if_instr", i), bus.if_instr, tbl[i].eins);
      end
      if (tbl[i].r) begin
        chk($sformatf("v%0d_rst_if_pc", i), bus.if_pc, 32'd0);
        chk($sformatf("v%0d_rst_if_instr", i), bus.if_instr, 32'd0);
      end
      chk($sformatf("v%0d_addr", i), bus.imem_addr, tbl[i].eaddr);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("v%0d_count", i), fetch_count, tbl[i].ec);
      chk($sformatf("v%0d_err", i), misalign_err, tbl[i].ee);
    end

    // loop the program by redirecting at end of memory: redirect must win
    // over end-of-memory, and fetch_count must saturate
    rst = 1'b1; start = 1'b0; halt_req = 1'b0;
    bus.redirect_valid = 1'b0; bus.if_ready = 1'b1;
    tick();
    rst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      bus.redirect_valid = (mpc == 32'd16);
      bus.redirect_pc    = 32'd0;
      tick();
    end
    bus.redirect_valid = 1'b0;
    chk("sat_count", fetch_count, CNT_MAX);
    chk("sat_busy", busy, 1'b1);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(99) == 0);
      start        = ($urandom_range(7) == 0);
      halt_req     = ($urandom_range(39) == 0);
      bus.if_ready = ($urandom_range(9) < 7);
      bus.redirect_valid = (mode == M_RUN) && !halt_req && ($urandom_range(9) == 0);
      case ($urandom_range(5))
        0: bus.redirect_pc = 32'd0;
        1: bus.redirect_pc = 32'd4;
        2: bus.redirect_pc = 32'd8;
        3: bus.redirect_pc = 32'd12;
        4: bus.redirect_pc = 32'($urandom_range(15));
        default: bus.redirect_pc = $urandom;
      endcase
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
